// File: rtl/rom_stream_reader_pkg.sv
// Shared types and default geometry for the ROM stream reader.
// Optional checksum: define ROM_STREAM_READER_CHECKSUM_EN.
package rom_stream_reader_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_AW    = 3;
    localparam int DEF_DW    = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream carrying ROM data and a burst-end marker.
// Optional checksum: define ROM_STREAM_READER_CHECKSUM_EN.
interface rom_stream_reader_if #(
    parameter int DW = 4
);
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/rom_stream_reader_addr_gen.sv
// Burst address walker: wrapping address counter plus words-remaining count.
// Optional checksum: define ROM_STREAM_READER_CHECKSUM_EN.
module rom_stream_reader_addr_gen
    import rom_stream_reader_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [AW:0]   load_len,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          is_last
);

    localparam logic [AW-1:0] A_ONE = 1;
    localparam logic [AW:0]   R_ONE = 1;

    logic [AW:0] remaining;

    // Load on burst start; advance and wrap on each captured word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= load_addr;
            remaining <= load_len;
        end else if (step) begin
            addr      <= addr + A_ONE;
            remaining <= remaining - R_ONE;
        end
    end

    assign is_last = (remaining == R_ONE);

endmodule

// File: rtl/rom_stream_reader.sv
// Handshaked burst reader over a small lookup ROM.
// Optional checksum: define ROM_STREAM_READER_CHECKSUM_EN.
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW:0]         len,
    output logic [AW-1:0]       rom_addr,
    input  logic [DW-1:0]       rom_data,
    rom_stream_reader_if.master m_if,
    output logic                busy,
    output logic                done,
    output logic [DW-1:0]       checksum
);

    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    state_t        state_q;
    state_t        state_d;
    logic [AW:0]   len_eff;
    logic          load;
    logic          step;
    logic          capture;
    logic          drain_ack;
    logic          done_d;
    logic          accept;
    logic          is_last;
    logic          slot_free;
    logic          m_valid_q;
    logic [DW-1:0] m_data_q;
    logic          m_last_q;
    logic          done_q;

    assign len_eff   = (len > DEPTH_L) ? DEPTH_L : len;
    assign slot_free = !m_valid_q || m_if.m_ready;

    rom_stream_reader_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_addr (base_addr),
        .load_len  (len_eff),
        .step      (step),
        .addr      (rom_addr),
        .is_last   (is_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        drain_ack = 1'b0;
        done_d    = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (slot_free) begin
                    capture = 1'b1;
                    step    = 1'b1;
                    if (is_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_if.m_ready) begin
                    drain_ack = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output slot: refilled whenever free in RUN, emptied on final acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= done_d;
            if (capture) begin
                m_valid_q <= 1'b1;
                m_data_q  <= rom_data;
                m_last_q  <= is_last;
            end else if (drain_ack) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

`ifdef ROM_STREAM_READER_CHECKSUM_EN
    logic [DW-1:0] csum_q;

    // Running sum of accepted words, cleared on each accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (m_valid_q && m_if.m_ready) begin
            csum_q <= csum_q + m_data_q;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign m_if.m_valid = m_valid_q;
    assign m_if.m_data  = m_data_q;
    assign m_if.m_last  = m_last_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a beat scoreboard.
// Honours ROM_STREAM_READER_CHECKSUM_EN for checksum expectations.
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] base_addr;
    logic [3:0] len;
    logic [2:0] rom_addr;
    logic [3:0] rom_data;
    logic       busy;
    logic       done;
    logic [3:0] checksum;

    int         n_cmp = 0;
    int         n_err = 0;
    int         hs_count = 0;
    logic [4:0] exp_q[$];
    logic [3:0] exp_sum = '0;

    logic       prev_stall = 1'b0;
    logic [3:0] prev_data;
    logic       prev_last;

    rom_stream_reader_if #(.DW(4)) m_if();

    rom_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m_if      (m_if),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // ROM contents: entry i holds 2*i.
    assign rom_data = {rom_addr, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_ck();
`ifdef ROM_STREAM_READER_CHECKSUM_EN
        return exp_sum;
`else
        return 4'd0;
`endif
    endfunction

    task automatic push_burst(input int base, input int l, output int n);
        int         a;
        logic [3:0] d;
        n = (l > 8) ? 8 : l;
        for (int i = 0; i < n; i++) begin
            a = (base + i) % 8;
            d = 4'(2 * a);
            exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, d});
            exp_sum = exp_sum + d;
        end
    endtask

    task automatic run_burst(input int base, input int l, input bit bp,
                             input bit poke, input int exp_cyc);
        int         n;
        int         cyc;
        logic [3:0] pat;
        pat      = 4'b1001;
        hs_count = 0;
        exp_sum  = '0;
        push_burst(base, l, n);
        base_addr = base[2:0];
        len       = l[3:0];
        start     = 1'b1;
        @(posedge clk);
        #1;
        start         = 1'b0;
        m_if.m_ready  = bp ? pat[0] : 1'b1;
        @(negedge clk);
        cyc = 1;
        if (n > 0) begin
            check("busy_after_start", busy, 1);
            check("rom_addr_base", rom_addr, base[2:0]);
        end else begin
            check("busy_len0", busy, 0);
        end
        while (!done && cyc < 60) begin
            @(posedge clk);
            #1;
            if (bp) m_if.m_ready = pat[cyc % 4];
            start = (poke && cyc == 2);
            if (start) begin
                base_addr = 3'd0;
                len       = 4'd8;
            end
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
        if (exp_cyc > 0) check("burst_cycles", cyc, exp_cyc);
        check("valid_at_done", m_if.m_valid, 0);
        check("busy_at_done", busy, 0);
        check("words_accepted", hs_count, n);
        check("queue_empty", exp_q.size(), 0);
        check("checksum", checksum, exp_ck());
        @(posedge clk);
        #1;
        m_if.m_ready = 1'b1;
        start        = 1'b0;
        @(negedge clk);
        check("done_pulse_width", done, 0);
        check("checksum_hold", checksum, exp_ck());
    endtask

    task automatic check_reset_values();
        check("rst_m_valid", m_if.m_valid, 0);
        check("rst_m_data", m_if.m_data, 0);
        check("rst_m_last", m_if.m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 0);
        check("rst_rom_addr", rom_addr, 0);
    endtask

    // Scoreboard side: pop on every handshake, watch stalled words for stability.
    always @(negedge clk) begin
        logic [4:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_if.m_valid, 1);
                check("hold_data", m_if.m_data, prev_data);
                check("hold_last", m_if.m_last, prev_last);
            end
            if (m_if.m_valid && m_if.m_ready) begin
                hs_count++;
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL extra_beat: observed data %0h expected no beat",
                           m_if.m_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", m_if.m_data, e[3:0]);
                    check("beat_last", m_if.m_last, e[4]);
                end
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_data  = m_if.m_data;
            prev_last  = m_if.m_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         n1;
        int         n2;
        int         cyc;
        logic [3:0] ck1;

        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        len          = '0;
        m_if.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);

        // plain, wrap, back-pressure, zero length, busy start, clamp
        run_burst(0, 8, 1'b0, 1'b0, 10);
        run_burst(6, 4, 1'b0, 1'b0, 6);
        run_burst(1, 3, 1'b1, 1'b0, 9);
        run_burst(0, 0, 1'b0, 1'b0, 1);
        run_burst(2, 5, 1'b0, 1'b1, 7);
        run_burst(5, 15, 1'b0, 1'b0, 10);

        // reset mid-burst after the second beat
        hs_count = 0;
        exp_sum  = '0;
        push_burst(0, 8, n1);
        base_addr = 3'd0;
        len       = 4'd8;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (hs_count < 2 && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("rst_wait_beats", hs_count, 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values();
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        run_burst(3, 2, 1'b0, 1'b0, 4);

        // back-to-back: start held across done
        hs_count = 0;
        exp_sum  = '0;
        push_burst(4, 2, n1);
        ck1     = exp_ck();
        exp_sum = '0;
        push_burst(5, 1, n2);
        base_addr = 3'd4;
        len       = 4'd2;
        start     = 1'b1;
        cyc       = 0;
        do begin
            @(posedge clk);
            #1;
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 40);
        check("b2b_done1", done, 1);
        check("b2b_checksum1", checksum, ck1);
        base_addr = 3'd5;
        len       = 4'd1;
        @(negedge clk);
        check("b2b_busy_restart", busy, 1);
        check("b2b_valid_d1", m_if.m_valid, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_valid_d2", m_if.m_valid, 1);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            cyc++;
        end
        check("b2b_done2", done, 1);
        check("b2b_words", hs_count, n1 + n2);
        check("b2b_queue_empty", exp_q.size(), 0);
        check("b2b_checksum2", checksum, exp_ck());
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Read initiator for the 8-entry, 4-bit lookup ROM. On a start request it walks a programmable window of ROM addresses, wrapping modulo depth, and streams each word out on a valid/ready interface. It sits between the ROM and any downstream consumer, replacing ad-hoc address driving with a handshaked, back-pressure-safe burst.

## Interface
- DEPTH, 8, ROM entries; power of two
- AW, 3, address width, log2(DEPTH)
- DW, 4, ROM data width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a burst; sampled only in IDLE
- base_addr  in  AW  first ROM address of the burst
- len  in  AW+1  number of words, 0..DEPTH
- rom_addr  out  AW  address to the ROM
- rom_data  in  DW  ROM read data, combinational from rom_addr, same cycle
- m_valid  out  1  output word valid
- m_data  out  DW  output word
- m_last  out  1  marks the final word of the burst; qualified by m_valid
- m_ready  in  1  consumer accepts the word when m_valid && m_ready
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at burst completion
- checksum  out  DW  burst checksum; see Configuration

## Operation
- States are IDLE, RUN and DRAIN.
- **IDLE**
  - When start=1: latch base_addr into the address counter, latch len into the remaining counter, then move to RUN.
  - If len=0: stay in IDLE, emit no beats, and pulse done on the next cycle.
- **RUN**
  - rom_addr equals the address counter.
  - The output slot is free when !m_valid || m_ready.
  - When the slot is free: m_data <= rom_data, m_valid <= 1, address counter +1 mod DEPTH, remaining -1.
  - When the captured word is the last one (remaining was 1): set m_last <= 1 and move to DRAIN.
- **DRAIN**
  - Hold m_valid, m_data and m_last until m_ready.
  - On acceptance: m_valid <= 0, m_last <= 0, done pulses for one cycle, move to IDLE.
- **Output stability:** m_data and m_last must not change while m_valid && !m_ready.
- **Address wrap:** base_addr=6 with len=4 reads addresses 6, 7, 0, 1.
- **len=DEPTH:** reads every entry exactly once.
- **start while busy:** ignored, with no effect on the current burst.
- **start coincident with the done pulse:** accepted, because the FSM is already in IDLE in that cycle.
- **rst mid-burst:** aborts the burst immediately; the in-flight word is dropped.
- **Reset values:** m_valid=0, m_data=0, m_last=0, busy=0, done=0, checksum=0, rom_addr=0, counters 0, state IDLE.
- **Out-of-range len:** len > DEPTH is clamped to DEPTH.

## Timing
- start sampled at edge N: busy=1 and rom_addr=base_addr after edge N.
- First m_valid rises after edge N+1.
- Throughput with m_ready held high: one word per cycle.
- A burst of L words completes with done high in the cycle after edge N+L+1.
- Back-pressure: each low-m_ready cycle on a pending word adds one cycle; no words are lost or duplicated.
- done and busy are registered outputs; there are no combinational paths from inputs to outputs except rom_addr → rom_data, which is external.

## Configuration
- Macro: ROM_STREAM_READER_CHECKSUM_EN.
- **Defined:**
  - checksum is the sum modulo 2^DW of all words accepted in the burst.
  - It is cleared when start is accepted, updated on each handshake, and stable from the done pulse until the next accepted start.
- **Undefined:** the checksum logic is not built and checksum is tied to 0.

## Structure
- Package rom_stream_reader_pkg contains:
  - state enum {IDLE, RUN, DRAIN}
  - default DEPTH, AW and DW localparams
- Sub-module rom_stream_reader_addr_gen:
  - loadable AW-bit address counter with increment-and-wrap
  - AW+1-bit remaining counter
  - is_last flag
- FSM and output register stay in the top module.

## Test plan
The ROM is loaded so that entry i = 2i: contents 0, 2, 4, …, 14.

1. **Plain burst:** base_addr=0, len=8, m_ready=1 → m_data 0, 2, 4, 6, 8, 10, 12, 14 on consecutive cycles; m_last only on 14; done one cycle later; checksum 8 (56 mod 16) when the macro is defined.
2. **Wrap:** base_addr=6, len=4 → m_data 12, 14, 0, 2; m_last on 2.
3. **Back-pressure:** base_addr=1, len=3, m_ready toggles 1, 0, 0, 1, … → m_data 2, 4, 6, each held stable while m_ready=0; exactly 3 handshakes.
4. **Zero length and busy start:** len=0 → done pulses and m_valid never rises. start pulsed again mid-burst → ignored; the burst word count is unchanged.
5. **Reset mid-burst:** assert rst after the 2nd beat → all outputs at reset values immediately. A new start with base_addr=3, len=2 then yields 6, 8.
6. **Back-to-back:** start held high across done → second burst begins, first m_valid two cycles after the done pulse.
